// File: rtl/warp_issue_scheduler.sv
`default_nettype none
// warp_issue_scheduler: per-slot FREE/READY/WAIT tracking with a round-robin
// pick of one READY warp per cycle into a valid/ready issue register.
module warp_issue_scheduler #(
   parameter  int NUM_WARPS = 16,
   localparam int WID_W     = $clog2(NUM_WARPS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             launch_valid,
   input  logic [WID_W-1:0] launch_wid,
   input  logic             wb_valid,
   input  logic [WID_W-1:0] wb_wid,
   input  logic             exit_valid,
   input  logic [WID_W-1:0] exit_wid,
   output logic             issue_valid,
   output logic [WID_W-1:0] issue_wid,
   input  logic             issue_ready,
   output logic [WID_W:0]   active_count,
   output logic             idle,
   output logic             err
);

   typedef enum logic [1:0] {
      S_FREE  = 2'd0,
      S_READY = 2'd1,
      S_WAIT  = 2'd2
   } slot_e;

   slot_e            slot_q [NUM_WARPS];
   slot_e            slot_d [NUM_WARPS];
   logic             issue_valid_q, issue_valid_d;
   logic [WID_W-1:0] issue_wid_q, issue_wid_d;
   logic [WID_W-1:0] rr_q, rr_d;
   logic [WID_W:0]   active_q, active_d;
   logic             idle_q, idle_d;
   logic             err_q, err_d;

   logic [NUM_WARPS-1:0] launch_hit;
   logic [NUM_WARPS-1:0] wb_hit;
   logic [NUM_WARPS-1:0] exit_hit;
   logic [NUM_WARPS-1:0] ready_vec;
   logic                 any_ready;
   logic [WID_W-1:0]     sel_wid;
   logic [WID_W-1:0]     scan_idx;
   logic                 fire;
   logic                 load;

   always_comb begin
      launch_hit = '0;
      wb_hit     = '0;
      exit_hit   = '0;
      if (launch_valid) launch_hit[launch_wid] = 1'b1;
      if (wb_valid)     wb_hit[wb_wid]         = 1'b1;
      if (exit_valid)   exit_hit[exit_wid]     = 1'b1;
   end

   always_comb begin
      ready_vec = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         ready_vec[i] = (slot_q[i] == S_READY);
      end
   end

   // Scan starts one past the last grant; the pointer itself is checked last.
   always_comb begin
      any_ready = 1'b0;
      sel_wid   = '0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_WARPS; k++) begin
         scan_idx = rr_q + k[WID_W-1:0];
         if (!any_ready && ready_vec[scan_idx]) begin
            any_ready = 1'b1;
            sel_wid   = scan_idx;
         end
      end
   end

   always_comb begin
      fire          = issue_valid_q & issue_ready;
      load          = (~issue_valid_q | fire) & any_ready;
      issue_valid_d = issue_valid_q;
      issue_wid_d   = issue_wid_q;
      rr_d          = rr_q;
      err_d         = err_q;
      active_d      = '0;

      if (load) begin
         issue_valid_d = 1'b1;
         issue_wid_d   = sel_wid;
         rr_d          = sel_wid;
      end else if (fire) begin
         issue_valid_d = 1'b0;
      end

      // Each event only acts on one source state, so the updates never collide.
      for (int i = 0; i < NUM_WARPS; i++) begin
         slot_d[i] = slot_q[i];
         if (load && (sel_wid == i[WID_W-1:0])) begin
            slot_d[i] = S_WAIT;
         end
         if (launch_hit[i]) begin
            if (slot_q[i] == S_FREE) slot_d[i] = S_READY;
            else                     err_d     = 1'b1;
         end
         if (exit_hit[i]) begin
            if (slot_q[i] == S_WAIT) slot_d[i] = S_FREE;
            else                     err_d     = 1'b1;
         end else if (wb_hit[i]) begin
            if (slot_q[i] == S_WAIT) slot_d[i] = S_READY;
            else                     err_d     = 1'b1;
         end
      end

      for (int i = 0; i < NUM_WARPS; i++) begin
         if (slot_d[i] != S_FREE) active_d = active_d + (WID_W+1)'(1);
      end
      idle_d = (active_d == '0) && !issue_valid_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            slot_q[i] <= S_FREE;
         end
         issue_valid_q <= 1'b0;
         issue_wid_q   <= '0;
         rr_q          <= {WID_W{1'b1}};
         active_q      <= '0;
         idle_q        <= 1'b1;
         err_q         <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            slot_q[i] <= slot_d[i];
         end
         issue_valid_q <= issue_valid_d;
         issue_wid_q   <= issue_wid_d;
         rr_q          <= rr_d;
         active_q      <= active_d;
         idle_q        <= idle_d;
         err_q         <= err_d;
      end
   end

   assign issue_valid  = issue_valid_q;
   assign issue_wid    = issue_wid_q;
   assign active_count = active_q;
   assign idle         = idle_q;
   assign err          = err_q;

endmodule
`default_nettype wire
